multicycle_ctrl: RTL

Multi-cycle successor to the single-cycle MIPS control unit: a Moore/Mealy FSM that sequences FETCH, DECODE, EXEC, MEM and WB over several clocks per instruction. It is parametrised in control-field widths and memory wait tolerance. It handshakes with instruction and data memories that may insert wait states. It drives the same datapath selects (npc_sel, mux4_5sel, mux4_32sel, mux2sel, ExtOp, ALUctr) plus the strobes a multi-cycle datapath needs (PCWrite, IRWrite, memory requests).

---
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (RESET/FETCH/DECODE/EXEC/MEM/WB) with memory wait-state timeout.
// Optional feature: define MCTRL_JAL_EN to decode jal (op 000011); otherwise it is illegal.
module multicycle_ctrl #(
    parameter int ALUCTR_W  = 3,
    parameter int NPC_SEL_W = 3,
    parameter int WAIT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 beqout,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 DMWrite,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrt,
    output logic [ALUCTR_W-1:0]  ALUctr,
    output logic [NPC_SEL_W-1:0] npc_sel,
    output logic [1:0]           ExtOp,
    output logic [1:0]           mux4_5sel,
    output logic [1:0]           mux4_32sel,
    output logic                 mux2sel,
    output logic                 instr_done,
    output logic                 illegal,
    output logic                 bus_err
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_e;

    typedef enum logic [3:0] {
        I_ILL, I_ADD, I_SUB, I_ADDIU, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JR, I_JAL
    } instr_e;

    typedef struct packed {
        logic [2:0] alu;
        logic [2:0] npc;
        logic [1:0] ext;
        logic [1:0] m5;
        logic [1:0] m32;
        logic       m2;
    } sel_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    function automatic instr_e decode_instr(input logic [5:0] op_i, input logic [5:0] funct_i);
        instr_e res;
        res = I_ILL;
        case (op_i)
            6'b000000: begin
                case (funct_i)
                    6'b100000: res = I_ADD;
                    6'b100010: res = I_SUB;
                    6'b001000: res = I_JR;
                    default:   res = I_ILL;
                endcase
            end
            6'b001001: res = I_ADDIU;
            6'b001111: res = I_LUI;
            6'b100011: res = I_LW;
            6'b101011: res = I_SW;
            6'b000100: res = I_BEQ;
            6'b000010: res = I_J;
`ifdef MCTRL_JAL_EN
            6'b000011: res = I_JAL;
`endif
            default:   res = I_ILL;
        endcase
        return res;
    endfunction

    function automatic sel_t sel_of(input instr_e i);
        sel_t s;
        s = '0;
        case (i)
            I_ADD:   begin s.alu = 3'b001; s.m5 = 2'b01; end
            I_SUB:   begin s.alu = 3'b010; s.m5 = 2'b01; end
            I_ADDIU: begin s.alu = 3'b001; s.ext = 2'b10; s.m2 = 1'b1; end
            I_LUI:   begin s.m32 = 2'b11; end
            I_LW:    begin s.alu = 3'b001; s.ext = 2'b10; s.m2 = 1'b1; s.m32 = 2'b01; end
            I_SW:    begin s.alu = 3'b001; s.ext = 2'b10; s.m2 = 1'b1; end
            I_BEQ:   begin s.alu = 3'b010; s.npc = 3'b011; end
            I_J:     begin s.npc = 3'b001; end
            I_JR:    begin s.npc = 3'b100; end
            I_JAL:   begin s.npc = 3'b001; s.m5 = 2'b10; s.m32 = 2'b10; end
            default: s = '0;
        endcase
        return s;
    endfunction

    state_e            state_q, state_d;
    instr_e            instr_q, instr_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    instr_e            dec_s, cur_instr_s;
    sel_t              sel_s;
    logic              drive_sel_s;

    // Decode is live in DECODE; later states use the class latched at the end of DECODE.
    assign dec_s       = decode_instr(op, funct);
    assign cur_instr_s = (state_q == S_DECODE) ? dec_s : instr_q;
    assign sel_s       = sel_of(cur_instr_s);

    // State, latched instruction class and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
            instr_q <= I_ILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; counter clears unless a wait cycle extends it.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = '0;
        drive_sel_s = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        DMWrite     = 1'b0;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        RegWrt      = 1'b0;
        ALUctr      = '0;
        npc_sel     = '0;
        ExtOp       = 2'b00;
        mux4_5sel   = 2'b00;
        mux4_32sel  = 2'b00;
        mux2sel     = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == WAIT_MAX) begin
                    bus_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                drive_sel_s = 1'b1;
                instr_d     = dec_s;
                if (dec_s == I_ILL) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                drive_sel_s = 1'b1;
                case (instr_q)
                    I_LW, I_SW: state_d = S_MEM;
                    I_BEQ: begin
                        PCWrite    = beqout;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    I_J, I_JR: begin
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    I_JAL: begin
                        PCWrite    = 1'b1;
                        RegWrt     = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                drive_sel_s = 1'b1;
                dmem_req    = 1'b1;
                DMWrite     = (instr_q == I_SW);
                if (dmem_ready) begin
                    if (instr_q == I_SW) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == WAIT_MAX) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                drive_sel_s = 1'b1;
                RegWrt      = 1'b1;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
        if (drive_sel_s) begin
            ALUctr     = ALUCTR_W'(sel_s.alu);
            npc_sel    = NPC_SEL_W'(sel_s.npc);
            ExtOp      = sel_s.ext;
            mux4_5sel  = sel_s.m5;
            mux4_32sel = sel_s.m32;
            mux2sel    = sel_s.m2;
        end else begin
            ALUctr     = '0;
            npc_sel    = '0;
            ExtOp      = 2'b00;
            mux4_5sel  = 2'b00;
            mux4_32sel = 2'b00;
            mux2sel    = 1'b0;
        end
    end

endmodule
